// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
//
// Write-back arbiter and busy scoreboard for the general-purpose register file.
// The ALU and the load/memory unit share the register file's single write port.
// Each side uses a valid/ready handshake, and a round-robin pointer arbitrates
// between them. The granted destination and data are registered onto the
// register file write port for exactly one cycle.
//
// A per-register busy scoreboard tracks writes that are still in flight. Issue
// logic stalls while the destination of the issuing instruction is busy.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   alu_valid/alu_dest/alu_data      ALU write-back request
//   alu_ready                        ALU granted this cycle (combinational)
//   mem_valid/mem_dest/mem_data      memory unit write-back request
//   mem_ready                        memory unit granted this cycle (combinational)
//   issue_valid/issue_dest           instruction issuing with a destination
//   issue_ready                      destination not busy (combinational)
//   reg_write_en/_dest/_data         registered register file write port
//   busy_vec                         bit i set = register i has a write pending
//   wb_err                           sticky: a write committed to a non-busy register
// -----------------------------------------------------------------------------
module gpr_wb_arbiter #(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 3,
   localparam int NREG   = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_dest,
   output logic              issue_ready,
   output logic              reg_write_en,
   output logic [ADDR_W-1:0] reg_write_dest,
   output logic [DATA_W-1:0] reg_write_data,
   output logic [NREG-1:0]   busy_vec,
   output logic              wb_err
);

   // Identity of the requester that received the most recent grant.
   typedef enum logic {
      GNT_ALU = 1'b0,
      GNT_MEM = 1'b1
   } gnt_e;

   gnt_e              r_last_gnt;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_dest;
   logic [DATA_W-1:0] r_wr_data;
   logic [NREG-1:0]   r_busy;
   logic              r_wb_err;

   logic              w_gnt_alu;
   logic              w_gnt_mem;
   logic              w_issue_ready;
   logic              w_issue_fire;
   logic [NREG-1:0]   w_set_mask;
   logic [NREG-1:0]   w_clr_mask;
   logic [NREG-1:0]   w_busy_nxt;
   logic              w_spurious;

   // Round-robin grant. It is gated by rst_n so that both readies drop as soon as reset asserts.
   always_comb begin
      w_gnt_alu = 1'b0;
      w_gnt_mem = 1'b0;
      if (!rst_n) begin
         w_gnt_alu = 1'b0;
         w_gnt_mem = 1'b0;
      end else begin
         case ({alu_valid, mem_valid})
            2'b10: w_gnt_alu = 1'b1;
            2'b01: w_gnt_mem = 1'b1;
            2'b11: begin
               // On contention, the side that was not granted most recently wins.
               if (r_last_gnt == GNT_MEM) begin
                  w_gnt_alu = 1'b1;
               end else begin
                  w_gnt_mem = 1'b1;
               end
            end
            default: begin
               w_gnt_alu = 1'b0;
               w_gnt_mem = 1'b0;
            end
         endcase
      end
   end

   // Scoreboard next state. Clears apply first so that a set on the same bit wins.
   always_comb begin
      w_set_mask    = {NREG{1'b0}};
      w_clr_mask    = {NREG{1'b0}};
      w_issue_ready = ~r_busy[issue_dest];
      w_issue_fire  = issue_valid & w_issue_ready;
      if (w_issue_fire) begin
         w_set_mask[issue_dest] = 1'b1;
      end else begin
         w_set_mask = {NREG{1'b0}};
      end
      if (r_wr_en) begin
         w_clr_mask[r_wr_dest] = 1'b1;
      end else begin
         w_clr_mask = {NREG{1'b0}};
      end
      w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
      // A commit to a register that has no write outstanding is a protocol error.
      w_spurious = r_wr_en & ~r_busy[r_wr_dest];
   end

   // Write-port register and round-robin pointer. Dest and data hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_en    <= 1'b0;
         r_wr_dest  <= {ADDR_W{1'b0}};
         r_wr_data  <= {DATA_W{1'b0}};
         r_last_gnt <= GNT_MEM;
      end else if (w_gnt_alu) begin
         r_wr_en    <= 1'b1;
         r_wr_dest  <= alu_dest;
         r_wr_data  <= alu_data;
         r_last_gnt <= GNT_ALU;
      end else if (w_gnt_mem) begin
         r_wr_en    <= 1'b1;
         r_wr_dest  <= mem_dest;
         r_wr_data  <= mem_data;
         r_last_gnt <= GNT_MEM;
      end else begin
         r_wr_en    <= 1'b0;
      end
   end

   // Busy scoreboard and sticky write-back error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= {NREG{1'b0}};
         r_wb_err <= 1'b0;
      end else begin
         r_busy   <= w_busy_nxt;
         r_wb_err <= r_wb_err | w_spurious;
      end
   end

   assign alu_ready      = w_gnt_alu;
   assign mem_ready      = w_gnt_mem;
   assign issue_ready    = w_issue_ready;
   assign reg_write_en   = r_wr_en;
   assign reg_write_dest = r_wr_dest;
   assign reg_write_data = r_wr_data;
   assign busy_vec       = r_busy;
   assign wb_err         = r_wb_err;

endmodule
